// File: rtl/game_flow_controller.sv
// game_flow_controller
// Top-level sequencer for the three-column note game. Edge-detects the start
// and pause buttons and walks the session through IDLE, COUNTDOWN, PLAY,
// PAUSE and OVER. Issues the note-manager start pulse and run enable, counts
// lives from misses, ramps the speed code as the score climbs and keeps the
// session high score.
//
// Optional feature macro: GH_HIGH_SCORE_EN
//   defined   -> high_score register and comparator are built
//   undefined -> high_score is tied to 0
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   start_btn    in   start button, synchronised, active-high
//   pause_btn    in   pause button, synchronised, active-high
//   score        in   current score from the datapath (unsigned, 17 bits)
//   note_hit     in   one-cycle pulse per scored note
//   note_miss    in   one-cycle pulse per missed note
//   dp_game_over in   game-over level from the note manager
//   state        out  IDLE=0 COUNTDOWN=1 PLAY=2 PAUSE=3 OVER=4
//   game_start   out  one-cycle pulse on the first PLAY cycle
//   game_run     out  high while state==PLAY
//   countdown    out  remaining countdown ticks
//   lives        out  remaining lives
//   speed_select out  speed code (000 slow .. 010 fast)
//   high_score   out  best final score since reset
//   game_over    out  high while state==OVER
module game_flow_controller #(
  parameter int TICK_DIV   = 25000000,
  parameter int COUNT_SECS = 3,
  parameter int LIVES      = 3,
  parameter int LEVEL_STEP = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic [16:0] score,
  input  logic        note_hit,
  input  logic        note_miss,
  input  logic        dp_game_over,
  output logic [2:0]  state,
  output logic        game_start,
  output logic        game_run,
  output logic [3:0]  countdown,
  output logic [3:0]  lives,
  output logic [2:0]  speed_select,
  output logic [16:0] high_score,
  output logic        game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COUNTDOWN = 3'd1;
  localparam logic [2:0] S_PLAY      = 3'd2;
  localparam logic [2:0] S_PAUSE     = 3'd3;
  localparam logic [2:0] S_OVER      = 3'd4;

  logic          start_prev;
  logic          pause_prev;
  logic          start_edge;
  logic          pause_edge;
  logic [TW-1:0] tick;
  logic          tick_wrap;
  logic [17:0]   threshold;
  logic          terminal_miss;
  logic          enter_over;

  // Hits only move the score, which the datapath owns; lives ignore them.
  logic unused_hit;
  assign unused_hit = note_hit;

  // Previous values reset to 1 so a button held through reset never fires.
  assign start_edge    = start_btn & ~start_prev;
  assign pause_edge    = pause_btn & ~pause_prev;
  assign tick_wrap     = (tick == TW'(TICK_DIV - 1));
  assign terminal_miss = note_miss && (lives == 4'd1);
  assign enter_over    = (state == S_PLAY) && (terminal_miss || dp_game_over);

  assign game_run  = (state == S_PLAY);
  assign game_over = (state == S_OVER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev   <= 1'b1;
      pause_prev   <= 1'b1;
      state        <= S_IDLE;
      countdown    <= 4'd0;
      lives        <= 4'(LIVES);
      speed_select <= 3'b000;
      threshold    <= 18'(LEVEL_STEP);
      tick         <= '0;
      game_start   <= 1'b0;
    end else begin
      start_prev <= start_btn;
      pause_prev <= pause_btn;
      game_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state        <= S_COUNTDOWN;
            countdown    <= 4'(COUNT_SECS);
            lives        <= 4'(LIVES);
            speed_select <= 3'b000;
            threshold    <= 18'(LEVEL_STEP);
            tick         <= '0;
          end
        end
        S_COUNTDOWN: begin
          if (tick_wrap) begin
            tick      <= '0;
            countdown <= countdown - 4'd1;
            if (countdown == 4'd1) begin
              state      <= S_PLAY;
              game_start <= 1'b1;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        S_PLAY: begin
          // A miss that coincides with a hit still costs a life.
          if (note_miss && (lives != 4'd0))
            lives <= lives - 4'd1;
          // Game-over outranks a pause edge in the same cycle.
          if (terminal_miss || dp_game_over)
            state <= S_OVER;
          else if (pause_edge)
            state <= S_PAUSE;
          // One level per cycle at most; a dropping score never lowers it.
          if (({1'b0, score} >= threshold) && (speed_select < 3'b010)) begin
            speed_select <= speed_select + 3'b001;
            threshold    <= threshold + 18'(LEVEL_STEP);
          end
        end
        S_PAUSE: begin
          if (pause_edge)
            state <= S_PLAY;
        end
        S_OVER: begin
          // lives and speed_select stay visible until the next countdown.
          if (start_edge)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GH_HIGH_SCORE_EN
  // Captured on the edge that enters OVER, using the final score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      high_score <= 17'd0;
    else if (enter_over && (score > high_score))
      high_score <= score;
  end
`else
  logic unused_over;
  assign unused_over = enter_over;
  assign high_score  = 17'd0;
`endif

endmodule

// File: tb/tb_game_flow_controller.sv
// Testbench for game_flow_controller with TICK_DIV=4, COUNT_SECS=3, LIVES=3,
// LEVEL_STEP=10. A vector table covers the countdown, speed ramp, pause and
// miss behaviour; hand-written sequences cover high score and async reset.
module tb_game_flow_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_btn;
  logic        pause_btn;
  logic [16:0] score;
  logic        note_hit;
  logic        note_miss;
  logic        dp_game_over;
  logic [2:0]  state;
  logic        game_start;
  logic        game_run;
  logic [3:0]  countdown;
  logic [3:0]  lives;
  logic [2:0]  speed_select;
  logic [16:0] high_score;
  logic        game_over;

`ifdef GH_HIGH_SCORE_EN
  localparam int HS_EN = 1;
`else
  localparam int HS_EN = 0;
`endif

  game_flow_controller #(
    .TICK_DIV(4), .COUNT_SECS(3), .LIVES(3), .LEVEL_STEP(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .pause_btn(pause_btn),
    .score(score), .note_hit(note_hit), .note_miss(note_miss),
    .dp_game_over(dp_game_over), .state(state), .game_start(game_start),
    .game_run(game_run), .countdown(countdown), .lives(lives),
    .speed_select(speed_select), .high_score(high_score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, pa, mi, hi, dg;
    logic [16:0] sc;
    int          e_state, e_cd, e_lives, e_spd, e_gs;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic st, pa, mi, hi, dg, input int sc,
                     input int es, ecd, el, esp, egs);
    vec_t v;
    v.st = st; v.pa = pa; v.mi = mi; v.hi = hi; v.dg = dg; v.sc = 17'(sc);
    v.e_state = es; v.e_cd = ecd; v.e_lives = el; v.e_spd = esp; v.e_gs = egs;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_session(input int sc, input int exp_hs, input int id);
    int n;
    start_btn = 1'b1; step(); chk("sess_idle", id, state, 0);
    start_btn = 1'b0; step();
    start_btn = 1'b1; step(); chk("sess_countdown", id, state, 1);
    start_btn = 1'b0;
    n = 0;
    while (state != 3'd2 && n < 20) begin
      step();
      n++;
    end
    chk("sess_play", id, state, 2);
    score = 17'(sc); dp_game_over = 1'b1; step();
    dp_game_over = 1'b0;
    chk("sess_over", id, state, 4);
    chk("sess_high_score", id, high_score, exp_hs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; start_btn = 1'b1; pause_btn = 1'b0; score = '0;
    note_hit = 1'b0; note_miss = 1'b0; dp_game_over = 1'b0;

    // ---- session 1: held start, countdown with ignored presses ----
    add(1,0,0,0,0, 0,  0,0,3,0,0);
    add(0,0,0,0,0, 0,  0,0,3,0,0);
    add(1,0,0,0,0, 0,  1,3,3,0,0);
    for (int k = 0; k < 11; k++)
      add((k == 8) ? 1'b1 : 1'b0, (k == 4) ? 1'b1 : 1'b0, 0,0,0, 0,
          1, 3 - (k + 1) / 4, 3, 0, 0);
    add(0,0,0,0,0, 0,  2,0,3,0,1);
    add(0,0,0,0,0, 0,  2,0,3,0,0);
    // speed ramp
    add(0,0,0,0,0, 35, 2,0,3,1,0);
    add(0,0,0,0,0, 35, 2,0,3,2,0);
    add(0,0,0,0,0, 35, 2,0,3,2,0);
    add(0,0,0,0,0, 60, 2,0,3,2,0);
    add(0,0,0,0,0, 5,  2,0,3,2,0);
    // pause freezes misses and game-over
    add(0,1,0,0,0, 5,  3,0,3,2,0);
    add(0,0,1,0,0, 5,  3,0,3,2,0);
    add(0,0,0,0,0, 5,  3,0,3,2,0);
    add(0,0,1,0,0, 5,  3,0,3,2,0);
    add(0,0,0,0,1, 5,  3,0,3,2,0);
    add(0,1,0,0,0, 5,  2,0,3,2,0);
    add(0,0,0,0,1, 5,  4,0,3,2,0);
    add(0,0,0,0,0, 5,  4,0,3,2,0);
    // ---- session 2: restart, levels held until countdown ----
    add(1,0,0,0,0, 0,  0,0,3,2,0);
    add(0,0,0,0,0, 0,  0,0,3,2,0);
    add(1,0,0,0,0, 0,  1,3,3,0,0);
    for (int k = 0; k < 11; k++)
      add(0,0,0,0,0, 0, 1, 3 - (k + 1) / 4, 3, 0, 0);
    add(0,0,0,0,0, 0,  2,0,3,0,1);
    // misses, hit+miss, terminal miss with simultaneous pause edge
    add(0,0,1,0,0, 0,  2,0,2,0,0);
    add(0,0,0,0,0, 0,  2,0,2,0,0);
    add(0,0,1,1,0, 0,  2,0,1,0,0);
    add(0,0,0,0,0, 0,  2,0,1,0,0);
    add(0,1,1,0,0, 0,  4,0,0,0,0);
    add(0,0,0,0,0, 0,  4,0,0,0,0);

    // reset values while held in reset
    step(); step();
    chk("rst_state", 0, state, 0);
    chk("rst_countdown", 0, countdown, 0);
    chk("rst_lives", 0, lives, 3);
    chk("rst_speed", 0, speed_select, 0);
    chk("rst_high_score", 0, high_score, 0);
    chk("rst_flags", 0, {game_start, game_run, game_over}, 0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      start_btn = vq[i].st; pause_btn = vq[i].pa; note_miss = vq[i].mi;
      note_hit = vq[i].hi; dp_game_over = vq[i].dg; score = vq[i].sc;
      step();
      chk("state", i, state, vq[i].e_state);
      chk("countdown", i, countdown, vq[i].e_cd);
      chk("lives", i, lives, vq[i].e_lives);
      chk("speed_select", i, speed_select, vq[i].e_spd);
      chk("game_start", i, game_start, vq[i].e_gs);
      chk("game_run", i, game_run, (vq[i].e_state == 2) ? 1 : 0);
      chk("game_over", i, game_over, (vq[i].e_state == 4) ? 1 : 0);
    end
    start_btn = 1'b0; pause_btn = 1'b0; note_miss = 1'b0; note_hit = 1'b0;
    dp_game_over = 1'b0; score = '0;

    // session 1 ended on dp_game_over with score 5, session 2 with score 0
    chk("high_score_after_table", 0, high_score, HS_EN ? 5 : 0);

    // ---- high score over two more sessions ----
    run_session(12, HS_EN ? 12 : 0, 1);
    run_session(7,  HS_EN ? 12 : 0, 2);

    // ---- asynchronous reset mid-countdown ----
    start_btn = 1'b1; step();
    start_btn = 1'b0; step();
    start_btn = 1'b1; step();
    start_btn = 1'b0;
    n = 0;
    while (countdown != 4'd2 && n < 10) begin
      step();
      n++;
    end
    chk("pre_reset_countdown", 0, countdown, 2);
    chk("pre_reset_state", 0, state, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 0, state, 0);
    chk("async_rst_countdown", 0, countdown, 0);
    chk("async_rst_lives", 0, lives, 3);
    chk("async_rst_speed", 0, speed_select, 0);
    chk("async_rst_high_score", 0, high_score, 0);
    chk("async_rst_flags", 0, {game_start, game_run, game_over}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_state", 0, state, 0);
    chk("post_reset_countdown", 0, countdown, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Top-level game sequencer for the three-column note game. Edge-detects the start and pause buttons and runs the session through idle, countdown, play, pause and game-over. Issues the note-manager start pulse and run enable, counts lives from miss events, and ramps `speed_select` as the score climbs. Also holds the session high score. Sits between the board buttons and the display/note datapath.

## Interface
- `TICK_DIV`, 25000000, clock cycles per countdown tick (1 s at 25 MHz)
- `COUNT_SECS`, 3, countdown length in ticks (1..15)
- `LIVES`, 3, misses allowed per session (1..15)
- `LEVEL_STEP`, 20, score points per speed level
- `clk` in 1: system clock
- `rst_n` in 1: reset; one clock; asynchronous, active-low
- `start_btn` in 1: start button, active-high, already synchronised
- `pause_btn` in 1: pause button, active-high, already synchronised
- `score` in 17: current score from the datapath, unsigned
- `note_hit` in 1: one-cycle pulse when a note is scored
- `note_miss` in 1: one-cycle pulse when a note leaves the play area unhit
- `dp_game_over` in 1: game-over level from the note manager
- `state` out 3: IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, OVER=4
- `game_start` out 1: one-cycle start pulse to the note manager
- `game_run` out 1: high exactly while `state`==PLAY
- `countdown` out 4: remaining countdown ticks
- `lives` out 4: remaining lives
- `speed_select` out 3: speed code to the datapath (000 slow, 001, 010 fast)
- `high_score` out 17: best final score since reset
- `game_over` out 1: high exactly while `state`==OVER

## Operation
- Button edges: each button has a previous-value register, reset to 1. An edge is `btn & ~prev`, so a button held through reset does not fire.
- IDLE: a start edge moves to COUNTDOWN. Entry loads `countdown`=COUNT_SECS, `lives`=LIVES, `speed_select`=000, level threshold=LEVEL_STEP, and clears the tick counter.
- COUNTDOWN: the tick counter runs 0..TICK_DIV-1. At TICK_DIV-1 it wraps and `countdown` decrements. When it wraps with `countdown`==1, `countdown` becomes 0 and the state moves to PLAY. Start and pause edges are ignored.
- PLAY:
  - `note_miss` decrements `lives`. At `lives`==1 a miss sets `lives`=0 and moves to OVER.
  - `dp_game_over` high also moves to OVER.
  - A pause edge moves to PAUSE. If a pause edge and a terminal miss land in the same cycle, OVER wins.
  - `note_hit` has no effect on `lives`. If `note_hit` and `note_miss` arrive in the same cycle, the miss is counted.
- Speed ramp, PLAY only: when `score` >= threshold and `speed_select` < 010, `speed_select` increments and the threshold increases by LEVEL_STEP. This is at most one step per cycle; catch-up happens over consecutive cycles. It saturates at 010. A falling score never lowers the level. The threshold is 18 bits wide so it cannot wrap.
- PAUSE: a pause edge returns to PLAY. `note_miss`, `dp_game_over` and the speed ramp are all frozen.
- OVER:
  - On entry, `high_score` is loaded with `score` if `score` > `high_score`.
  - A start edge moves to IDLE.
  - `lives` and `speed_select` hold their values until the next COUNTDOWN entry.
- Any state with `rst_n` low: immediate return to reset values, including mid-countdown and mid-play.

## Timing
- Reset values: `state`=IDLE, `countdown`=0, `lives`=LIVES, `speed_select`=000, `high_score`=0, `game_start`=0, `game_run`=0, `game_over`=0, tick counter 0.
- All outputs are registered or decoded directly from `state`. None depends combinationally on inputs.
- A start edge sampled at cycle t gives `state`=COUNTDOWN at t+1.
- PLAY begins at t+1+COUNT_SECS*TICK_DIV.
- `game_start` is high only in the first PLAY cycle. It does not re-fire on PAUSE→PLAY.
- A miss or event at cycle t updates `lives`/`state` at t+1. `high_score` updates at the cycle OVER is entered.

## Configuration
- `GH_HIGH_SCORE_EN` defined: the `high_score` register and comparator are built as described.
- `GH_HIGH_SCORE_EN` undefined: `high_score` is tied to 0 and no register is synthesised. All other behaviour is unchanged.

## Test plan
Bench parameters: TICK_DIV=4, COUNT_SECS=3, LIVES=3, LEVEL_STEP=10.

1. Reset with `start_btn` held high, release, then one start pulse at cycle t -> `state`=1 at t+1; `countdown` 3,2,1 for 4 cycles each; `state`=2 and `game_start`=1 at t+13 only.
2. In PLAY, three `note_miss` pulses -> `lives` 2,1,0; `state`=4 and `game_over`=1 the cycle after the third pulse.
3. In PLAY, drive `score`=35 -> `speed_select` steps 001 then 010 on consecutive cycles; `score`=60 later keeps 010; `score`=5 keeps 010.
4. Pause edge, then two `note_miss` pulses and `dp_game_over`=1 while paused -> `lives` unchanged, `state`=3. A second pause edge -> `state`=2, then `dp_game_over` -> `state`=4.
5. Finish sessions with scores 12 then 7 -> `high_score`=12 after both (with `GH_HIGH_SCORE_EN`); 0 without it.
6. Assert `rst_n`=0 mid-countdown with `countdown`=2 -> all outputs return to reset values in the same cycle, asynchronously.
